// File: rtl/muxn_pipe_pkg.sv
// Shared types for the registered N-to-1 operand selector: FSM state encoding,
// stored-entry layout and the state-to-handshake decode helpers.
package muxn_pipe_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   // Entry layout at the datapath's native width; the top builds the same
   // layout at its own SIZE.
   localparam int unsigned ENTRY_SIZE = 32;

   typedef struct packed {
      logic signed [ENTRY_SIZE-1:0] data;
      logic                         err;
   } entry_t;

   function automatic logic st_out_valid(input state_t st);
      return st != ST_EMPTY;
   endfunction

   // Ready depends only on registered state, keeping out_ready off the in_ready path.
   function automatic logic st_in_ready(input state_t st);
      return st != ST_FULL;
   endfunction

endpackage

// File: rtl/mux_n_to_1.sv
// Combinational N-to-1 selector with out-of-range detection; usable standalone
// in the datapath wherever a binary-encoded operand select is needed.
module mux_n_to_1 #(
   parameter int unsigned             SIZE        = 32,
   parameter int unsigned             NUM_IN      = 4,
   parameter int unsigned             SEL_W       = $clog2(NUM_IN),
   parameter logic signed [SIZE-1:0]  DEFAULT_VAL = '0
) (
   input  logic [SEL_W-1:0]       sel,
   input  logic [NUM_IN*SIZE-1:0] data,
   output logic [SIZE-1:0]        y,
   output logic                   err
);

   // A select matching no input leaves the defaults in place, which is the
   // out-of-range case; for power-of-two NUM_IN err folds to a constant 0.
   always_comb begin
      y   = DEFAULT_VAL;
      err = 1'b1;
      for (int unsigned k = 0; k < NUM_IN; k++) begin
         if (sel == SEL_W'(k)) begin
            y   = data[k*SIZE +: SIZE];
            err = 1'b0;
         end
      end
   end

endmodule

// File: rtl/muxn_pipe.sv
// Registered N-to-1 operand select with a valid/ready handshake backed by a
// two-entry skid buffer and a synchronous flush for pipeline squashes.
module muxn_pipe
   import muxn_pipe_pkg::*;
#(
   parameter int unsigned            SIZE        = 32,
   parameter int unsigned            NUM_IN      = 4,
   localparam int unsigned           SEL_W       = $clog2(NUM_IN),
   parameter logic signed [SIZE-1:0] DEFAULT_VAL = '0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [SEL_W-1:0]         in_sel,
   input  logic [NUM_IN*SIZE-1:0]   in_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [SIZE-1:0]   out_data,
   output logic                     out_err
);

   typedef struct packed {
      logic signed [SIZE-1:0] data;
      logic                   err;
   } slot_t;

   state_t          state_q, state_d;
   slot_t           main_q, main_d;
   slot_t           skid_q, skid_d;
   slot_t           sel_entry;
   logic [SIZE-1:0] sel_data;
   logic            sel_err;
   logic            in_xfer;
   logic            out_xfer;

   mux_n_to_1 #(
      .SIZE        (SIZE),
      .NUM_IN      (NUM_IN),
      .SEL_W       (SEL_W),
      .DEFAULT_VAL (DEFAULT_VAL)
   ) u_mux (
      .sel  (in_sel),
      .data (in_data),
      .y    (sel_data),
      .err  (sel_err)
   );

   assign sel_entry = '{data: sel_data, err: sel_err};

   assign out_valid = st_out_valid(state_q);
   assign in_ready  = st_in_ready(state_q);
   assign out_data  = main_q.data;
   assign out_err   = main_q.err;

   assign in_xfer  = in_valid & in_ready;
   assign out_xfer = out_valid & out_ready;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      case (state_q)
         ST_EMPTY: begin
            if (in_xfer) begin
               main_d  = sel_entry;
               state_d = ST_ONE;
            end
         end
         ST_ONE: begin
            if (in_xfer && out_xfer) begin
               main_d = sel_entry;
            end else if (in_xfer) begin
               skid_d  = sel_entry;
               state_d = ST_FULL;
            end else if (out_xfer) begin
               state_d = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (out_xfer) begin
               main_d  = skid_q;
               state_d = ST_ONE;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
      // Data registers may still load on a flush; the state alone marks them dead.
      if (flush) begin
         state_d = ST_EMPTY;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

endmodule

// File: tb/tb_muxn_pipe.sv
// Scoreboard bench for muxn_pipe: the driver pushes expected entries for accepted
// inputs, a separate monitor checks the handshake and pops on output transfers.
module tb_muxn_pipe;

   localparam int SIZE   = 32;
   localparam int NUM_IN = 3;
   localparam int SEL_W  = $clog2(NUM_IN);
   localparam logic [SIZE-1:0] DEF = 32'h5A5A_0001;

   logic                   clk = 1'b0;
   logic                   rst_n;
   logic                   flush;
   logic                   in_valid;
   logic                   in_ready;
   logic [SEL_W-1:0]       in_sel;
   logic [NUM_IN*SIZE-1:0] in_data;
   logic                   out_valid;
   logic                   out_ready;
   logic signed [SIZE-1:0] out_data;
   logic                   out_err;

   always #5 clk = ~clk;

   muxn_pipe #(
      .SIZE        (SIZE),
      .NUM_IN      (NUM_IN),
      .DEFAULT_VAL (DEF)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_sel    (in_sel),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_err   (out_err)
   );

   typedef struct {
      logic [SIZE-1:0] data;
      logic            err;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;
   bit   exp_in_ready = 1'b1;

   task automatic check(input string name, input logic [SIZE-1:0] act,
                        input logic [SIZE-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
      end
   endtask

   // Reference: pick input `sel` from the flattened vector, or the default when out of range.
   function automatic exp_t ref_sel(input logic [SEL_W-1:0] s,
                                    input logic [NUM_IN*SIZE-1:0] d);
      exp_t e;
      int   idx;
      idx = int'(s);
      if (idx < NUM_IN) begin
         e.data = d[idx*SIZE +: SIZE];
         e.err  = 1'b0;
      end else begin
         e.data = DEF;
         e.err  = 1'b1;
      end
      return e;
   endfunction

   // Monitor: runs 3 time units after each falling edge, ahead of the driver's bookkeeping.
   initial begin
      forever begin
         @(negedge clk);
         #3;
         exp_in_ready = sb_q.size() < 2;
         check("out_valid", SIZE'(out_valid), SIZE'(sb_q.size() > 0));
         check("in_ready", SIZE'(in_ready), SIZE'(exp_in_ready));
         if (sb_q.size() > 0) begin
            check("out_data", out_data, sb_q[0].data);
            check("out_err", SIZE'(out_err), SIZE'(sb_q[0].err));
            if (out_ready) void'(sb_q.pop_front());
         end
      end
   end

   task automatic cyc(input bit v, input logic [SEL_W-1:0] s,
                      input logic [NUM_IN*SIZE-1:0] d, input bit ordy, input bit fl,
                      output bit acc);
      @(negedge clk);
      in_valid  = v;
      in_sel    = s;
      in_data   = d;
      out_ready = ordy;
      flush     = fl;
      #4;
      acc = v && exp_in_ready && !fl;
      if (fl) sb_q.delete();
      else if (acc) sb_q.push_back(ref_sel(s, d));
   endtask

   function automatic logic [NUM_IN*SIZE-1:0] rnd_data();
      return {$urandom, $urandom, $urandom};
   endfunction

   task automatic async_reset();
      @(negedge clk);
      in_valid  = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b0;
      #1;
      rst_n = 1'b0;
      sb_q.delete();
      #1;
      check("rst_out_valid", SIZE'(out_valid), '0);
      check("rst_out_data", out_data, '0);
      check("rst_out_err", SIZE'(out_err), '0);
      check("rst_in_ready", SIZE'(in_ready), 1);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit acc;
      int nready;
      int nvalid;
      logic [NUM_IN*SIZE-1:0] d;

      rst_n     = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_sel    = '0;
      in_data   = '0;
      out_ready = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      check("init_out_valid", SIZE'(out_valid), '0);
      check("init_out_data", out_data, '0);
      check("init_in_ready", SIZE'(in_ready), 1);
      @(negedge clk);
      rst_n = 1'b1;

      // Basic select: input 2 of {3,2,1}.
      d = {32'd3, 32'd2, 32'd1};
      cyc(1, 2'd2, d, 1, 0, acc);
      cyc(0, 2'd0, '0, 1, 0, acc);
      check("basic_valid", SIZE'(out_valid), 1);
      check("basic_data", out_data, 3);
      check("basic_err", SIZE'(out_err), 0);

      // Out of range select.
      cyc(1, 2'd3, rnd_data(), 1, 0, acc);
      cyc(0, 2'd0, '0, 1, 0, acc);
      check("oor_data", out_data, DEF);
      check("oor_err", SIZE'(out_err), 1);
      cyc(0, 2'd0, '0, 1, 0, acc);

      // Backpressure: A, B absorbed, C held until the stall clears.
      cyc(1, 2'd0, {32'd0, 32'd0, 32'hA}, 0, 0, acc);
      check("bp_ready_a", SIZE'(in_ready), 1);
      cyc(1, 2'd0, {32'd0, 32'd0, 32'hB}, 0, 0, acc);
      check("bp_ready_b", SIZE'(in_ready), 1);
      for (int i = 0; i < 3; i++) begin
         cyc(1, 2'd0, {32'd0, 32'd0, 32'hC}, 0, 0, acc);
         check("bp_stall_c", SIZE'(in_ready), 0);
         check("bp_hold_data", out_data, 32'hA);
      end
      cyc(1, 2'd0, {32'd0, 32'd0, 32'hC}, 1, 0, acc);
      check("bp_release", SIZE'(in_ready), 0);
      cyc(1, 2'd0, {32'd0, 32'd0, 32'hC}, 1, 0, acc);
      check("bp_accept_c", SIZE'(in_ready), 1);
      check("bp_data_b", out_data, 32'hB);
      repeat (3) cyc(0, 2'd0, '0, 1, 0, acc);

      // Full throughput: 100 back-to-back transfers.
      nready = 0;
      nvalid = 0;
      for (int i = 0; i < 100; i++) begin
         cyc(1, SEL_W'($urandom_range(0, NUM_IN - 1)), rnd_data(), 1, 0, acc);
         if (in_ready) nready++;
         if (i > 0 && out_valid) nvalid++;
      end
      check("tput_ready", nready, 100);
      check("tput_valid", nvalid, 99);
      cyc(0, 2'd0, '0, 1, 0, acc);
      check("tput_last_valid", SIZE'(out_valid), 1);
      cyc(0, 2'd0, '0, 1, 0, acc);
      check("tput_drained", SIZE'(out_valid), 0);

      // Flush while full with in_valid asserted.
      cyc(1, 2'd0, rnd_data(), 0, 0, acc);
      cyc(1, 2'd1, rnd_data(), 0, 0, acc);
      cyc(1, 2'd2, rnd_data(), 0, 1, acc);
      cyc(0, 2'd0, '0, 1, 0, acc);
      check("flush_valid", SIZE'(out_valid), 0);
      check("flush_ready", SIZE'(in_ready), 1);
      cyc(1, 2'd1, {32'd0, 32'h1234_5678, 32'd0}, 1, 0, acc);
      cyc(0, 2'd0, '0, 1, 0, acc);
      check("post_flush_data", out_data, 32'h1234_5678);

      // Asynchronous reset mid-stream, then resume.
      cyc(1, 2'd0, rnd_data(), 0, 0, acc);
      cyc(1, 2'd1, rnd_data(), 0, 0, acc);
      async_reset();
      cyc(1, 2'd2, {32'hFEED_0002, 32'd0, 32'd0}, 1, 0, acc);
      cyc(0, 2'd0, '0, 1, 0, acc);
      check("post_rst_data", out_data, 32'hFEED_0002);

      // Randomized traffic including stalls, out-of-range selects and flushes.
      for (int i = 0; i < 400; i++) begin
         cyc($urandom_range(0, 9) < 7, SEL_W'($urandom_range(0, 3)), rnd_data(),
             $urandom_range(0, 9) < 6, $urandom_range(0, 29) == 0, acc);
      end
      repeat (4) cyc(0, 2'd0, '0, 1, 0, acc);
      check("final_empty", SIZE'(out_valid), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/muxn_pipe.md
# muxn_pipe

Parametrised N-to-1 operand selector with a registered, flow-controlled output. It replaces the plain combinational 2:1 select in the RV32 datapath wherever a selected operand crosses a pipeline boundary, such as the forwarding select feeding EX or the writeback-source select. It adds:
- N inputs;
- out-of-range select detection;
- a valid/ready handshake backed by a 2-entry skid buffer, so stalls do not break timing on the ready path;
- a synchronous flush for branch/trap squashes.

## Interface
- SIZE, 32: data width of each input and of the output; data is treated as signed.
- NUM_IN, 4: number of data inputs, range 2..16.
- SEL_W, $clog2(NUM_IN): select width (derived; do not override).
- DEFAULT_VAL, 0: value driven when the select is out of range.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- flush  in  1  synchronous squash of all buffered entries.
- in_valid  in  1  input transfer request.
- in_ready  out  1  buffer can accept this cycle.
- in_sel  in  SEL_W  select, binary-encoded; sampled with in_valid.
- in_data  in  NUM_IN*SIZE  flattened inputs; input k occupies bits [k*SIZE +: SIZE].
- out_valid  out  1  out_data/out_err hold a valid entry.
- out_ready  in  1  consumer accepts this cycle.
- out_data  out  SIZE  selected value.
- out_err  out  1  entry was captured with in_sel >= NUM_IN.

## Operation
Transfer rules:
- An input transfer happens when in_valid & in_ready; an output transfer happens when out_valid & out_ready.
- On an input transfer, the captured value is in_data[in_sel*SIZE +: SIZE] and err=0.
- If in_sel >= NUM_IN, the captured value is DEFAULT_VAL and err=1.
- Selection happens before the register, so the output never depends combinationally on in_sel or in_data.

Storage and states:
- Storage is a main register (drives the outputs) plus a skid register.
- EMPTY: out_valid=0, in_ready=1.
  - input transfer -> ONE (main loaded).
- ONE: out_valid=1, in_ready=1.
  - input and output transfer -> ONE (main reloaded).
  - input transfer with !out_ready -> FULL (skid loaded).
  - output transfer only -> EMPTY.
  - neither -> hold.
- FULL: out_valid=1, in_ready=0.
  - output transfer -> ONE (skid copied into main).
  - otherwise hold.

Flush:
- flush=1 forces EMPTY next cycle regardless of in_valid or out_ready.
- No transfer is recorded that cycle. The output transfer still completes if the consumer samples it that cycle.
- Data registers need not clear on flush.

Other rules:
- in_ready is decoded from registered state only; there is no combinational path from out_ready to in_ready.
- Output ordering is strictly FIFO; no entry is duplicated or dropped except by flush.
- Values are passed bit-exact; no extension or truncation.

## Timing
- Reset (rst_n=0, asynchronous): state=EMPTY, out_valid=0, out_data=0, out_err=0, in_ready=1.
- Reset may be asserted mid-transfer; it discards all entries immediately.
- Latency: an input transfer in cycle t gives out_valid=1 in cycle t+1.
- Throughput: one transfer per cycle while out_ready=1.
- Stall: with out_ready low, at most 2 entries are absorbed; in_ready drops in the cycle after the second accept.
- Simultaneous in/out transfer in ONE: the new entry appears at t+1 with no bubble.
- While out_valid=1 and out_ready=0, out_data and out_err stay stable.

## Structure
- Package muxn_pipe_pkg holds:
  - the state enum: ST_EMPTY, ST_ONE, ST_FULL (2 bits);
  - a typedef for the stored entry: struct of data[SIZE] plus err.
- Sub-module mux_n_to_1: combinational, parametrised on SIZE and NUM_IN, producing the selected value and the err flag. It can be reused standalone in the datapath.
- The top level contains only the state machine, the two entry registers and the handshake decode.

## Test plan
- Basic select: NUM_IN=4, in_data={4,3,2,1}, in_sel=2, out_ready=1 -> out_data=3, out_err=0 one cycle later.
- Out of range: NUM_IN=3, in_sel=3 -> out_data=DEFAULT_VAL, out_err=1.
- Backpressure: stream 0xA,0xB,0xC with out_ready=0 -> in_ready=0 after 0xB; release -> outputs A,B,C in order, C accepted only after release.
- Full throughput: 100 back-to-back transfers, out_ready=1 -> out_valid continuous from cycle 1, no bubbles, order preserved.
- Flush while FULL with in_valid=1 -> next cycle out_valid=0, in_ready=1, and the squashed entries never appear.
- Async reset pulsed mid-stream between clock edges -> outputs go to 0 immediately, state EMPTY, traffic resumes correctly after release.
